// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
// Build option: define XZR_BYPASS_EN to return zero for register 31.
module regfile_read_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic                   stall,
   output logic [NREQ-1:0]        gnt,
   output logic [ADDR_W-1:0]      port_sel,
   input  logic [DATA_W-1:0]      port_data,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   logic [NREQ-1:0]   cand;
   logic              found;
   logic [PTR_W-1:0]  win_id;
   logic [ADDR_W-1:0] win_addr;
   logic [PTR_W-1:0]  ptr_q, ptr_d;

   logic              s1_v_q;
   logic [PTR_W-1:0]  s1_id_q;
   logic [ADDR_W-1:0] port_sel_q;
   logic              s2_v_q;
   logic [PTR_W-1:0]  s2_id_q;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef XZR_BYPASS_EN
   logic              s1_zero_q;
`endif

   assign cand = req & ~{NREQ{stall}};

   // Scan starts at ptr and wraps, so the requester just served drops to lowest priority.
   always_comb begin
      int idx;
      idx      = 0;
      found    = 1'b0;
      win_id   = '0;
      win_addr = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && cand[idx]) begin
            found    = 1'b1;
            win_id   = PTR_W'(idx);
            win_addr = req_addr[idx*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (found)
         ptr_d = (win_id == PTR_W'(NREQ-1)) ? '0 : win_id + 1'b1;
   end

   always_comb begin
      rsp_data_d = port_data;
`ifdef XZR_BYPASS_EN
      if (s1_zero_q) rsp_data_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         s1_v_q     <= 1'b0;
         s1_id_q    <= '0;
         port_sel_q <= '0;
         s2_v_q     <= 1'b0;
         s2_id_q    <= '0;
         rsp_data_q <= '0;
`ifdef XZR_BYPASS_EN
         s1_zero_q  <= 1'b0;
`endif
      end else begin
         ptr_q  <= ptr_d;
         s1_v_q <= found;
         s2_v_q <= s1_v_q;
         // Select and data only move on a live transfer so the mux bank sees no idle toggling.
         if (found) begin
            port_sel_q <= win_addr;
            s1_id_q    <= win_id;
`ifdef XZR_BYPASS_EN
            s1_zero_q  <= (win_addr == ADDR_W'(31));
`endif
         end
         if (s1_v_q) begin
            s2_id_q    <= s1_id_q;
            rsp_data_q <= rsp_data_d;
         end
      end
   end

   assign gnt       = (found && !reset) ? (ONE << win_id) : '0;
   assign port_sel  = port_sel_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_valid = s2_v_q ? (ONE << s2_id_q) : '0;
   assign busy      = s1_v_q | s2_v_q;

endmodule
